pipeline_run_ctrl: RTL and testbench

Run/stop sequencer for the five-stage SIMPLE pipeline. It turns the Exec and Step buttons, the decoded HLT, a PC breakpoint and a cycle budget into one pipeline clock-enable (`ce`) plus a fetch-gating signal (`fetch_en`). It replaces the ad-hoc `systemStopped` gating: every stage register, the PC and the cycle counter take `ce` from this block.

---
 rtl/pipeline_run_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_run_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_ctrl.sv
// rtl/pipeline_run_ctrl.sv - run/step/halt sequencer producing pipeline ce and fetch gating
// Optional breakpoint compare built only when RUN_CTRL_BREAKPOINT_EN is defined.
module pipeline_run_ctrl #(
    parameter int CYC_W     = 32,
    parameter int DRAIN_LEN = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             exec_pulse,
    input  logic             step_pulse,
    input  logic             halt_req,
    input  logic [15:0]      pc,
    input  logic             bp_en,
    input  logic [15:0]      bp_addr,
    input  logic [15:0]      budget,
    output logic             ce,
    output logic             fetch_en,
    output logic             running,
    output logic             halted,
    output logic [2:0]       stop_cause,
    output logic [CYC_W-1:0] cycle_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_PAUSE  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    localparam logic [2:0] C_USER   = 3'd1;
    localparam logic [2:0] C_BP     = 3'd2;
    localparam logic [2:0] C_BUDGET = 3'd3;
    localparam logic [2:0] C_HALT   = 3'd4;

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_LEN - 1);

    logic [2:0]       state_q, state_d;
    logic [15:0]      seg_q, seg_d;
    logic [7:0]       drain_q, drain_d;
    logic [2:0]       cause_q, cause_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             fetch_en_q, running_q, halted_q;
    logic             bp_hit, budget_hit, enter_run, ce_c;

    assign enter_run = ((state_q == S_IDLE) || (state_q == S_PAUSE)) && exec_pulse;

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic bp_skip_q, bp_skip_d;

    // bp_skip lets the first RUN cycle execute at a PC that just triggered a stop
    assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip_q;

    always_comb begin
        bp_skip_d = bp_skip_q;
        if (enter_run) begin
            bp_skip_d = 1'b1;
        end else if (state_q == S_RUN) begin
            bp_skip_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bp_skip_q <= 1'b0;
        end else begin
            bp_skip_q <= bp_skip_d;
        end
    end
`else
    logic unused_bp;
    assign unused_bp = &{1'b0, bp_en, bp_addr};
    assign bp_hit    = 1'b0;
`endif

    assign ce_c = ((state_q == S_RUN) && !bp_hit) || (state_q == S_STEP) || (state_q == S_DRAIN);
    assign budget_hit = (budget != 16'd0) && ((seg_q + 16'd1) == budget) && ce_c;

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        drain_d = drain_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE, S_PAUSE: begin
                if (exec_pulse) begin
                    state_d = S_RUN;
                    seg_d   = 16'd0;
                end else if (step_pulse) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (ce_c) begin
                    seg_d = seg_q + 16'd1;
                end
                if (halt_req) begin
                    state_d = S_DRAIN;
                    drain_d = 8'd0;
                end else if (bp_hit) begin
                    state_d = S_PAUSE;
                    cause_d = C_BP;
                end else if (budget_hit) begin
                    state_d = S_PAUSE;
                    cause_d = C_BUDGET;
                end else if (exec_pulse) begin
                    state_d = S_PAUSE;
                    cause_d = C_USER;
                end
            end
            S_STEP: begin
                if (halt_req) begin
                    state_d = S_DRAIN;
                    drain_d = 8'd0;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_HALTED;
                    cause_d = C_HALT;
                end else begin
                    drain_d = drain_q + 8'd1;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_d = cyc_q;
        if (ce_c && (cyc_q != {CYC_W{1'b1}})) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            seg_q      <= 16'd0;
            drain_q    <= 8'd0;
            cause_q    <= 3'd0;
            cyc_q      <= '0;
            fetch_en_q <= 1'b1;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            drain_q    <= drain_d;
            cause_q    <= cause_d;
            cyc_q      <= cyc_d;
            fetch_en_q <= !((state_d == S_DRAIN) || (state_d == S_HALTED));
            running_q  <= (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
            halted_q   <= (state_d == S_HALTED);
        end
    end

    assign ce          = ce_c;
    assign fetch_en    = fetch_en_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign stop_cause  = cause_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb/tb_pipeline_run_ctrl.sv - scoreboard bench for pipeline_run_ctrl
module tb_pipeline_run_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        exec_pulse, step_pulse, halt_req;
    logic [15:0] pc, bp_addr, budget;
    logic        bp_en;
    logic        ce, fetch_en, running, halted;
    logic [2:0]  stop_cause;
    logic [3:0]  cycle_count;

    logic        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    pipeline_run_ctrl #(.CYC_W(4), .DRAIN_LEN(3)) dut (
        .clock(clock), .reset(reset),
        .exec_pulse(exec_pulse), .step_pulse(step_pulse), .halt_req(halt_req),
        .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr), .budget(budget),
        .ce(ce), .fetch_en(fetch_en), .running(running), .halted(halted),
        .stop_cause(stop_cause), .cycle_count(cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: drive pulses, expected ce goes in, popped at negedge
    task automatic cyc(input logic ex, input logic st, input logic hl, input logic exp_ce, input string tag);
        logic e;
        exec_pulse = ex;
        step_pulse = st;
        halt_req   = hl;
        exp_q.push_back(exp_ce);
        @(negedge clock);
        e = exp_q.pop_front();
        chk(tag, {31'd0, ce}, {31'd0, e});
        @(posedge clock);
        #1;
        if (exp_ce) pc = pc + 16'd1;
        exec_pulse = 1'b0;
        step_pulse = 1'b0;
        halt_req   = 1'b0;
    endtask

    task automatic idle_n(input int n, input logic exp_ce, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, exp_ce, tag);
    endtask

    task automatic outs(input string tag, input logic r, input logic h, input logic f,
                        input logic [2:0] c, input int cc);
        chk({tag, "_running"}, {31'd0, running}, {31'd0, r});
        chk({tag, "_halted"}, {31'd0, halted}, {31'd0, h});
        chk({tag, "_fetch_en"}, {31'd0, fetch_en}, {31'd0, f});
        chk({tag, "_cause"}, {29'd0, stop_cause}, {29'd0, c});
        chk({tag, "_cycles"}, {28'd0, cycle_count}, cc);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        pc    = 16'h0010;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        chk({tag, "_ce"}, {31'd0, ce}, 32'd0);
        outs(tag, 1'b0, 1'b0, 1'b1, 3'd0, 0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; exec_pulse = 1'b0; step_pulse = 1'b0; halt_req = 1'b0;
        pc = 16'h0010; bp_en = 1'b0; bp_addr = 16'h0012; budget = 16'd0;
        @(posedge clock);
        #1;

        // exec at cycle 5, exec again at cycle 15
        do_reset("rst1");
        idle_n(5, 1'b0, "t1_idle");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "t1_go");
        idle_n(9, 1'b1, "t1_run");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "t1_stop");
        outs("t1", 1'b0, 1'b0, 1'b1, 3'd1, 10);
        idle_n(2, 1'b0, "t1_paused");

        // budget of 7 per segment
        do_reset("rst2");
        budget = 16'd7;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "t2_go");
        idle_n(7, 1'b1, "t2_seg1");
        outs("t2a", 1'b0, 1'b0, 1'b1, 3'd3, 7);
        idle_n(2, 1'b0, "t2_gap");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "t2_go2");
        idle_n(7, 1'b1, "t2_seg2");
        idle_n(1, 1'b0, "t2_end");
        outs("t2b", 1'b0, 1'b0, 1'b1, 3'd3, 14);
        budget = 16'd0;

        // three step pulses from IDLE
        do_reset("rst3");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "t3_s1");
        chk("t3_step_running", {31'd0, running}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t3_ce1");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "t3_s2");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t3_ce2");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "t3_s3");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t3_ce3");
        idle_n(2, 1'b0, "t3_paused");
        outs("t3", 1'b0, 1'b0, 1'b1, 3'd0, 3);

        // halt during RUN drains three cycles then locks
        do_reset("rst4");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "t4_go");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t4_run");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "t4_hlt");
        chk("t4_fetch_off", {31'd0, fetch_en}, 32'd0);
        chk("t4_drain_running", {31'd0, running}, 32'd1);
        idle_n(3, 1'b1, "t4_drain");
        outs("t4", 1'b0, 1'b1, 1'b0, 3'd4, 5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "t4_exec_ign");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "t4_after_exec");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "t4_step_ign");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "t4_after_step");
        outs("t4b", 1'b0, 1'b1, 1'b0, 3'd4, 5);

        // breakpoint at 0x0012
        do_reset("rst5");
        bp_en = 1'b1;
        bp_addr = 16'h0012;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "t5_go");
        idle_n(2, 1'b1, "t5_run");
`ifdef RUN_CTRL_BREAKPOINT_EN
        chk("t5_pc_at_bp", {16'd0, pc}, 32'h12);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "t5_bp_hit");
        outs("t5a", 1'b0, 1'b0, 1'b1, 3'd2, 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "t5_resume");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t5_skip_bp");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t5_run2");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "t5_stop");
        outs("t5b", 1'b0, 1'b0, 1'b1, 3'd1, 5);
`else
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t5_no_bp");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "t5_stop");
        outs("t5", 1'b0, 1'b0, 1'b1, 3'd1, 4);
`endif
        idle_n(1, 1'b0, "t5_paused");

        // halt coinciding with breakpoint, then reset mid-drain
        do_reset("rst6");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "t6_go");
        idle_n(2, 1'b1, "t6_run");
`ifdef RUN_CTRL_BREAKPOINT_EN
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "t6_hlt_bp");
`else
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "t6_hlt_bp");
`endif
        chk("t6_drain_running", {31'd0, running}, 32'd1);
        chk("t6_drain_fetch", {31'd0, fetch_en}, 32'd0);
        chk("t6_drain_cause", {29'd0, stop_cause}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t6_drain1");
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "t6_drain_rst");
        chk("t6_rst_ce", {31'd0, ce}, 32'd0);
        outs("t6_rst", 1'b0, 1'b0, 1'b1, 3'd0, 0);
        reset = 1'b1;
        bp_en = 1'b0;
        idle_n(2, 1'b0, "t6_idle");

        // cycle counter saturates at all-ones
        do_reset("rst7");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "t7_go");
        idle_n(18, 1'b1, "t7_run");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "t7_stop");
        outs("t7", 1'b0, 1'b0, 1'b1, 3'd1, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
